// File: rtl/audio_dac_out.sv
// audio_dac_out: converts 8-bit offset-binary audio samples into a 1-bit
// second-order sigma-delta PDM stream. A gain ramp fades audio in and out
// so that enabling/disabling never produces a step (click) at the output.
module audio_dac_out #(
   parameter int RAMP_SHIFT = 8
) (
   input  logic       clk48,
   input  logic       rst_n,
   input  logic [7:0] sample_in,
   input  logic       sample_valid,
   input  logic       enable,
   input  logic [1:0] atten,
   output logic       pdm_out,
   output logic       muted,
   output logic       active
);

   localparam int DATA_W = 8;
   localparam int COEF_W = 9;
   localparam int Y_W    = 18;
   localparam int ACC_W  = 20;
   localparam int EXT_W  = ACC_W + 2;

   localparam logic [COEF_W-1:0]       GAIN_FULL = 9'd256;
   localparam logic [COEF_W-1:0]       GAIN_ZERO = 9'd0;
   localparam logic signed [ACC_W-1:0] SAT_HI    = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_LO    = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [EXT_W-1:0] LIM_HI    = {2'b00, SAT_HI};
   localparam logic signed [EXT_W-1:0] LIM_LO    = {2'b11, SAT_LO};
   localparam logic signed [EXT_W-1:0] FB_POS    = 22'sd32768;
   localparam logic signed [EXT_W-1:0] FB_NEG    = -22'sd32768;

   typedef enum logic [1:0] {
      S_MUTE     = 2'd0,
      S_FADE_IN  = 2'd1,
      S_RUN      = 2'd2,
      S_FADE_OUT = 2'd3
   } state_t;

   state_t                  r_state;
   logic [COEF_W-1:0]       r_gain;
   logic [RAMP_SHIFT-1:0]   r_cnt;
   logic                    r_muted;
   logic                    r_active;
   logic [DATA_W-1:0]       r_hold;
   logic signed [Y_W-1:0]   r_y_p0;
   logic signed [ACC_W-1:0] r_i1_p1;
   logic signed [ACC_W-1:0] r_i2_p1;
   logic                    r_pdm_p1;

   logic                    w_wrap;
   logic [RAMP_SHIFT-1:0]   w_cnt_inc;
   logic [COEF_W-1:0]       w_gain_inc;
   logic [COEF_W-1:0]       w_gain_dec;
   logic signed [EXT_W-1:0] w_fb;
   logic signed [EXT_W-1:0] w_y_ext;
   logic signed [EXT_W-1:0] w_i1_ext;
   logic signed [EXT_W-1:0] w_i2_ext;
   logic signed [EXT_W-1:0] w_sum1;
   logic signed [EXT_W-1:0] w_sum2;
   logic signed [EXT_W-1:0] w_i1n_ext;
   logic signed [ACC_W-1:0] w_i1_next;
   logic signed [ACC_W-1:0] w_i2_next;

   // Clamp a widened integrator sum into the signed 20-bit range (no wrap).
   function automatic logic signed [ACC_W-1:0] sat20(input logic signed [EXT_W-1:0] v);
      if (v > LIM_HI) return SAT_HI;
      if (v < LIM_LO) return SAT_LO;
      return $signed(v[ACC_W-1:0]);
   endfunction

   // Offset-binary to signed, multiply by unsigned gain, then attenuate.
   function automatic logic signed [Y_W-1:0] scale(input logic [DATA_W-1:0] h,
                                                   input logic [COEF_W-1:0] g,
                                                   input logic [1:0]        sh);
      logic signed [DATA_W-1:0] x;
      logic signed [Y_W-1:0]    xe;
      logic signed [Y_W-1:0]    ge;
      logic signed [Y_W-1:0]    p;
      x  = $signed(h ^ 8'h80);
      xe = {{(Y_W-DATA_W){x[DATA_W-1]}}, x};
      ge = $signed({{(Y_W-COEF_W){1'b0}}, g});
      p  = xe * ge;
      return p >>> sh;
   endfunction

   // Ramp helpers and the two integrator updates (i2 uses the fresh i1).
   always_comb begin
      w_wrap     = &r_cnt;
      w_cnt_inc  = r_cnt + RAMP_SHIFT'(1);
      w_gain_inc = r_gain + 9'd1;
      w_gain_dec = r_gain - 9'd1;
      w_fb       = r_pdm_p1 ? FB_POS : FB_NEG;
      w_y_ext    = {{(EXT_W-Y_W){r_y_p0[Y_W-1]}}, r_y_p0};
      w_i1_ext   = {{(EXT_W-ACC_W){r_i1_p1[ACC_W-1]}}, r_i1_p1};
      w_i2_ext   = {{(EXT_W-ACC_W){r_i2_p1[ACC_W-1]}}, r_i2_p1};
      w_sum1     = w_i1_ext + w_y_ext - w_fb;
      w_i1_next  = sat20(w_sum1);
      w_i1n_ext  = {{(EXT_W-ACC_W){w_i1_next[ACC_W-1]}}, w_i1_next};
      w_sum2     = w_i2_ext + w_i1n_ext - w_fb;
      w_i2_next  = sat20(w_sum2);
   end

   // Fade state machine: gain ramp, step counter and registered indicators.
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_MUTE;
         r_gain   <= GAIN_ZERO;
         r_cnt    <= '0;
         r_muted  <= 1'b1;
         r_active <= 1'b0;
      end else begin
         case (r_state)
            S_MUTE: begin
               r_gain <= GAIN_ZERO;
               r_cnt  <= '0;
               if (enable) begin
                  r_state <= S_FADE_IN;
                  r_muted <= 1'b0;
               end
            end
            S_FADE_IN: begin
               r_cnt <= w_cnt_inc;
               if (w_wrap && r_gain != GAIN_FULL) r_gain <= w_gain_inc;
               if (!enable) begin
                  r_state <= S_FADE_OUT;
               end else if (r_gain == GAIN_FULL || (w_wrap && w_gain_inc == GAIN_FULL)) begin
                  r_state  <= S_RUN;
                  r_cnt    <= '0;
                  r_active <= 1'b1;
               end
            end
            S_RUN: begin
               r_gain <= GAIN_FULL;
               r_cnt  <= '0;
               if (!enable) begin
                  r_state  <= S_FADE_OUT;
                  r_active <= 1'b0;
               end
            end
            S_FADE_OUT: begin
               r_cnt <= w_cnt_inc;
               if (w_wrap && r_gain != GAIN_ZERO) r_gain <= w_gain_dec;
               if (enable) begin
                  r_state <= S_FADE_IN;
               end else if (r_gain == GAIN_ZERO || (w_wrap && w_gain_dec == GAIN_ZERO)) begin
                  r_state <= S_MUTE;
                  r_cnt   <= '0;
                  r_muted <= 1'b1;
               end
            end
            default: begin
               r_state  <= S_MUTE;
               r_gain   <= GAIN_ZERO;
               r_cnt    <= '0;
               r_muted  <= 1'b1;
               r_active <= 1'b0;
            end
         endcase
      end
   end

   // Stage p0: sample capture and registered scaled loop input
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         r_hold <= 8'h80;
         r_y_p0 <= '0;
      end else begin
         if (sample_valid) r_hold <= sample_in;
         r_y_p0 <= scale(r_hold, r_gain, atten);
      end
   end

   // Stage p1: saturating integrators and 1-bit quantiser
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         r_i1_p1  <= '0;
         r_i2_p1  <= '0;
         r_pdm_p1 <= 1'b0;
      end else begin
         r_i1_p1  <= w_i1_next;
         r_i2_p1  <= w_i2_next;
         r_pdm_p1 <= ~w_i2_next[ACC_W-1];
      end
   end

   assign pdm_out = r_pdm_p1;
   assign muted   = r_muted;
   assign active  = r_active;

endmodule

// File: tb/tb_audio_dac_out.sv
// tb_audio_dac_out: self-checking bench for audio_dac_out with a short ramp.
module tb_audio_dac_out;

   localparam int RS       = 2;
   localparam int FADE_CYC = 256 << RS;

   logic       clk48 = 1'b0;
   logic       rst_n;
   logic [7:0] sample_in;
   logic       sample_valid;
   logic       enable;
   logic [1:0] atten;
   logic       pdm_out;
   logic       muted;
   logic       active;

   audio_dac_out #(.RAMP_SHIFT(RS)) dut (
      .clk48        (clk48),
      .rst_n        (rst_n),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .enable       (enable),
      .atten        (atten),
      .pdm_out      (pdm_out),
      .muted        (muted),
      .active       (active)
   );

   always #10 clk48 = ~clk48;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: loop equations in plain integers, gain from elapsed time.
   int m_i1, m_i2, m_y, m_hold, m_gain, m_edge, m_on, m_off, m_state;
   bit m_pdm;
   int mm_pdm, mm_ind, mm_gain, ones;

   typedef struct {
      logic [7:0] hold;
      logic [1:0] att;
      int         cycles;
      int         exp_ones;
      int         tol;
   } vec_t;
   vec_t vecs[6];

   function automatic int sat20(input int v);
      if (v > 524287) return 524287;
      if (v < -524288) return -524288;
      return v;
   endfunction

   function automatic int gain_at(input int e);
      int t;
      if (m_on < 0) return 0;
      if (m_off < 0 || e < m_off) begin
         t = (e - m_on) >> RS;
         return (t > 256) ? 256 : t;
      end
      t = 256 - ((e - m_off) >> RS);
      return (t < 0) ? 0 : t;
   endfunction

   // 0 mute, 1 fading in, 2 run, 3 fading out
   function automatic int state_at(input int e);
      if (m_on < 0) return 0;
      if (m_off < 0) return (e - m_on >= FADE_CYC) ? 2 : 1;
      return (e - m_off >= FADE_CYC) ? 0 : 3;
   endfunction

   task automatic model_reset();
      m_i1 = 0; m_i2 = 0; m_y = 0; m_pdm = 1'b0; m_hold = 128;
      m_gain = 0; m_edge = 0; m_on = -1; m_off = -1; m_state = 0;
   endtask

   task automatic model_edge();
      int fb;
      int e;
      e    = m_edge;
      fb   = m_pdm ? 32768 : -32768;
      m_i1 = sat20(m_i1 + m_y - fb);
      m_i2 = sat20(m_i2 + m_i1 - fb);
      m_pdm = (m_i2 >= 0);
      m_y  = ((m_hold - 128) * m_gain) >>> atten;
      if (sample_valid) m_hold = int'(sample_in);
      if (m_on < 0 && enable) m_on = e;
      else if (m_on >= 0 && m_off < 0 && !enable) m_off = e;
      m_gain  = gain_at(e);
      m_state = state_at(e);
      m_edge  = e + 1;
   endtask

   task automatic tick();
      @(posedge clk48);
      model_edge();
      @(negedge clk48);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   task automatic check_tol(input string name, input int act, input int exp_v, input int tol);
      n_tests++;
      if (act < exp_v - tol || act > exp_v + tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp_v, tol);
      end
   endtask

   task automatic clear_mm();
      mm_pdm = 0; mm_ind = 0; mm_gain = 0; ones = 0;
   endtask

   task automatic cyc_check();
      if (pdm_out !== m_pdm) mm_pdm++;
      if ({muted, active} !== {(m_state == 0), (m_state == 2)}) mm_ind++;
      if (dut.r_gain !== m_gain[8:0]) mm_gain++;
      if (pdm_out === 1'b1) ones++;
   endtask

   task automatic drive_rand();
      sample_valid = ($urandom_range(0, 3) == 0);
      sample_in    = 8'($urandom);
      if ($urandom_range(0, 63) == 0) atten = 2'($urandom);
   endtask

   task automatic run_chk(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         cyc_check();
      end
   endtask

   task automatic strobe(input logic [7:0] v);
      sample_in    = v;
      sample_valid = 1'b1;
      tick();
      cyc_check();
      sample_valid = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_outs"}, {61'd0, pdm_out, muted, active}, 64'd2);
      check({tag, "_hold"}, {56'd0, dut.r_hold}, 64'h80);
      check({tag, "_gain_cnt"}, {53'd0, dut.r_gain, dut.r_cnt}, 64'd0);
      check({tag, "_integ"}, {24'd0, dut.r_i1_p1, dut.r_i2_p1}, 64'd0);
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int g, prev_g, mono_bad, rise, fall, first_chg, hit;
      vecs[0] = '{8'hC0, 2'd0, 8192, 6144, 8};
      vecs[1] = '{8'h40, 2'd0, 8192, 2048, 8};
      vecs[2] = '{8'hC0, 2'd2, 8192, 4608, 8};
      vecs[3] = '{8'h80, 2'd1, 2048, 1024, 4};
      vecs[4] = '{8'hFF, 2'd0, 16384, 16320, 164};
      vecs[5] = '{8'h00, 2'd0, 16384, 0, 164};

      rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_in = 8'h80; atten = 2'd0;
      model_reset();
      repeat (2) @(negedge clk48);
      check_reset_vals("reset_init");
      rst_n = 1'b1;

      // idle: muted loop with a full-scale sample present
      clear_mm();
      strobe(8'hFF);
      clear_mm();
      run_chk(1024);
      check_tol("idle_ones", ones, 512, 4);
      check("idle_pdm_exact", mm_pdm, 0);
      check("idle_indicators", mm_ind, 0);
      check("idle_muted_active", {62'd0, muted, active}, 64'd2);

      // fade-in with random traffic
      clear_mm();
      mono_bad = 0; rise = -1; prev_g = int'(dut.r_gain);
      enable = 1'b1;
      for (int k = 0; k < FADE_CYC + 64 && rise < 0; k++) begin
         drive_rand();
         tick();
         cyc_check();
         g = int'(dut.r_gain);
         if (g < prev_g || g > prev_g + 1) mono_bad++;
         prev_g = g;
         if (active === 1'b1) rise = m_edge - 1 - m_on;
      end
      sample_valid = 1'b0;
      check_tol("fadein_active_delay", rise, FADE_CYC, 1);
      check("fadein_gain_monotonic", mono_bad, 0);
      check("fadein_gain_final", {55'd0, dut.r_gain}, 64'd256);
      check("fadein_pdm_exact", mm_pdm, 0);
      check("fadein_gain_model", mm_gain, 0);
      check("fadein_indicators", mm_ind, 0);

      // table-driven density vectors in RUN
      for (int v = 0; v < 6; v++) begin
         atten = vecs[v].att;
         strobe(vecs[v].hold);
         run_chk(16);
         clear_mm();
         run_chk(vecs[v].cycles);
         check_tol($sformatf("dens_%02x_a%0d_ones", vecs[v].hold, vecs[v].att), ones, vecs[v].exp_ones, vecs[v].tol);
         check($sformatf("dens_%02x_a%0d_pdm_exact", vecs[v].hold, vecs[v].att), mm_pdm, 0);
         check($sformatf("dens_%02x_a%0d_integ", vecs[v].hold, vecs[v].att),
               {24'd0, dut.r_i1_p1, dut.r_i2_p1}, {24'd0, m_i1[19:0], m_i2[19:0]});
      end

      // latency: strobe at edge n reaches the loop input at edge n+1
      atten = 2'd0;
      strobe(8'h80);
      run_chk(8);
      clear_mm();
      sample_in = 8'hFF; sample_valid = 1'b1;
      tick(); cyc_check();
      sample_valid = 1'b0;
      check("lat_y_edge_n", dut.r_y_p0, 64'd0);
      tick(); cyc_check();
      check("lat_y_edge_n1", dut.r_y_p0, 64'd32512);
      run_chk(4);
      check("lat_pdm_exact", mm_pdm, 0);

      // random samples, strobes and attenuation in RUN
      clear_mm();
      for (int k = 0; k < 3000; k++) begin
         drive_rand();
         tick();
         cyc_check();
      end
      sample_valid = 1'b0;
      check("rand_pdm_exact", mm_pdm, 0);
      check("rand_indicators", mm_ind, 0);

      // fade-out
      clear_mm();
      mono_bad = 0; fall = -1; prev_g = int'(dut.r_gain);
      enable = 1'b0;
      for (int k = 0; k < FADE_CYC + 64 && fall < 0; k++) begin
         drive_rand();
         tick();
         cyc_check();
         g = int'(dut.r_gain);
         if (g > prev_g || g < prev_g - 1) mono_bad++;
         prev_g = g;
         if (muted === 1'b1) fall = m_edge - 1 - m_off;
      end
      sample_valid = 1'b0;
      check_tol("fadeout_muted_delay", fall, FADE_CYC, 1);
      check("fadeout_gain_monotonic", mono_bad, 0);
      check("fadeout_gain_final", {55'd0, dut.r_gain}, 64'd0);
      check("fadeout_pdm_exact", mm_pdm, 0);
      check("fadeout_gain_model", mm_gain, 0);

      // fade reversal: up to 100, down to 40, back up
      enable = 1'b1; hit = 0;
      for (int k = 0; k < 600 && hit == 0; k++) begin
         tick();
         if (dut.r_gain === 9'd100) hit = 1;
      end
      check("rev_reach_100", hit, 1);
      enable = 1'b0; mono_bad = 0; first_chg = -1; prev_g = 100; hit = 0;
      for (int k = 0; k < 600 && hit == 0; k++) begin
         tick();
         g = int'(dut.r_gain);
         if (g != prev_g && g != prev_g - 1) mono_bad++;
         if (first_chg < 0 && g != prev_g) first_chg = g;
         prev_g = g;
         if (g == 40) hit = 1;
      end
      check("rev_down_first_step", first_chg, 99);
      check("rev_down_no_jump", mono_bad, 0);
      check("rev_reach_40", hit, 1);
      check("rev_down_indicators", {62'd0, muted, active}, 64'd0);
      enable = 1'b1; mono_bad = 0; first_chg = -1; prev_g = 40;
      for (int k = 0; k < 40; k++) begin
         tick();
         g = int'(dut.r_gain);
         if (g != prev_g && g != prev_g + 1) mono_bad++;
         if (first_chg < 0 && g != prev_g) first_chg = g;
         prev_g = g;
      end
      check("rev_up_first_step", first_chg, 41);
      check("rev_up_no_jump", mono_bad, 0);
      hit = 0;
      for (int k = 0; k < FADE_CYC + 64 && hit == 0; k++) begin
         tick();
         if (active === 1'b1) hit = 1;
      end
      check("rev_reach_run", hit, 1);

      // asynchronous reset in the middle of a RUN cycle
      #5;
      rst_n = 1'b0;
      #1;
      check_reset_vals("reset_async");
      @(negedge clk48);
      rst_n = 1'b1; enable = 1'b0;
      model_reset();
      clear_mm();
      run_chk(32);
      check("post_reset_pdm_exact", mm_pdm, 0);
      check("post_reset_indicators", mm_ind, 0);
      enable = 1'b1;
      tick();
      check("post_reset_fadein_entry", {62'd0, muted, active}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
